// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register map, FSM states and STATUS layout for irq_controller
package irq_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int STATUS_BIT = 31;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - one interrupt channel: synchroniser chain plus rising-edge detector
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - N-channel interrupt controller with pending/mask/mode registers and fixed priority
module irq_controller #(
    parameter int N_CHANNELS  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CHANNELS-1:0] irq_in,
    input  logic                  start,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [31:0]           data,
    output logic [31:0]           q,
    output logic                  done,
    output logic                  cpu_irq,
    output logic [ID_W-1:0]       cpu_id,
    input  logic                  cpu_ack
);

    import irq_pkg::*;

    logic [N_CHANNELS-1:0] level;
    logic [N_CHANNELS-1:0] rise;
    logic [N_CHANNELS-1:0] pending_q;
    logic [N_CHANNELS-1:0] pending;
    logic [N_CHANNELS-1:0] mask_q;
    logic [N_CHANNELS-1:0] mode_q;
    logic [N_CHANNELS-1:0] eligible;
    logic [N_CHANNELS-1:0] id_onehot;
    logic [N_CHANNELS-1:0] ack_clr;
    logic [N_CHANNELS-1:0] w1c_clr;
    logic [ID_W-1:0]       winner_id;
    logic                  any_eligible;
    logic                  winner_still;
    logic                  wr;
    logic [31:0]           rd_data;
    logic                  data_unused;
    state_t                state_q;
    state_t                state_d;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .irq_in(irq_in[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    // Level-mode channels track the synchronised input directly; only edge-mode bits are latched.
    assign pending      = (pending_q & mode_q) | (level & ~mode_q);
    assign eligible     = pending & mask_q;
    assign any_eligible = |eligible;
    assign cpu_irq      = (state_q == REQ);

    always_comb begin
        winner_id = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (eligible[i]) winner_id = ID_W'(i);
        end
    end

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            id_onehot[i] = (cpu_id == ID_W'(i));
        end
    end

    assign winner_still = |(eligible & id_onehot);
    assign ack_clr      = id_onehot & {N_CHANNELS{cpu_irq & cpu_ack}};
    assign wr           = start & we;
    assign w1c_clr      = (wr && addr == REG_PENDING) ? data[N_CHANNELS-1:0] : '0;
    assign data_unused  = ^data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_eligible) state_d = REQ;
            REQ:     if (cpu_ack || !winner_still) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cpu_id  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_eligible) cpu_id <= winner_id;
        end
    end

    // A new edge in the same cycle as a W1C or ack clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= ((pending_q & ~w1c_clr & ~ack_clr) | rise) & mode_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            mode_q <= '1;
        end else if (wr) begin
            if (addr == REG_MASK) mask_q <= data[N_CHANNELS-1:0];
            if (addr == REG_MODE) mode_q <= data[N_CHANNELS-1:0];
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_PENDING: rd_data[N_CHANNELS-1:0] = pending;
            REG_MASK:    rd_data[N_CHANNELS-1:0] = mask_q;
            REG_MODE:    rd_data[N_CHANNELS-1:0] = mode_q;
            REG_STATUS: begin
                rd_data[STATUS_BIT] = cpu_irq;
                rd_data[ID_W-1:0]   = cpu_id;
            end
            default:     rd_data = '0;
        endcase
    end

    // Writes return zero on q so a stale read value is never mistaken for write feedback.
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            done <= 1'b0;
        end else begin
            done <= start;
            if (start) q <= we ? 32'd0 : rd_data;
        end
    end

endmodule
